// File: rtl/alu_exec_buffer.sv
// Execute stage: evaluates one ALU operation per accepted request and queues the
// result, flags and destination tag in a 2-entry FIFO with valid/ready on both sides.
module alu_exec_buffer #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              illegal_o,
    output logic [TAG_W-1:0]  tag_o
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1010
    } op_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              ovf;
        logic              illegal;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t      slots [2];
    entry_t      new_entry;
    entry_t      head;
    logic        wr;
    logic        rd;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              sign_a;
    logic              sign_b;

    assign sum    = src1_i + src2_i;
    assign diff   = src1_i - src2_i;
    assign sign_a = src1_i[DATA_W-1];
    assign sign_b = src2_i[DATA_W-1];

    // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        new_entry         = '0;
        new_entry.tag     = tag_i;
        unique case (op_e'(alu_ctrl_i))
            OP_AND: new_entry.result = src1_i & src2_i;
            OP_OR:  new_entry.result = src1_i | src2_i;
            OP_NOR: new_entry.result = ~(src1_i | src2_i);
            OP_ADD: begin
                new_entry.result = sum;
                new_entry.ovf    = (sign_a == sign_b) && (sum[DATA_W-1] != sign_a);
            end
            OP_SUB: begin
                new_entry.result = diff;
                new_entry.ovf    = (sign_a != sign_b) && (diff[DATA_W-1] != sign_a);
            end
            // Exact signed compare; the subtraction sign is wrong when it overflows.
            OP_SLT: new_entry.result = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: new_entry.illegal = 1'b1;
        endcase
        new_entry.zero = (new_entry.result == '0);
    end

    assign in_ready_o  = rst_i && !flush_i && (count != 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count <= 2'd0;
            wr    <= 1'b0;
            rd    <= 1'b0;
        end else if (flush_i) begin
            count <= 2'd0;
            wr    <= 1'b0;
            rd    <= 1'b0;
        end else begin
            if (push) wr <= ~wr;
            if (pop)  rd <= ~rd;
            if (push && !pop)      count <= count + 2'd1;
            else if (!push && pop) count <= count - 2'd1;
        end
    end

    // NOTE: slot storage is not reset; the head is masked to zero whenever count is 0.
    always_ff @(posedge clk_i) begin
        if (push) slots[wr] <= new_entry;
    end

    assign head        = out_valid_o ? slots[rd] : '0;
    assign result_o    = head.result;
    assign zero_o      = head.zero;
    assign ovf_o       = head.ovf;
    assign illegal_o   = head.illegal;
    assign tag_o       = head.tag;

endmodule

// File: tb/tb_alu_exec_buffer.sv
// Directed bench for alu_exec_buffer: ALU results/flags, FIFO backpressure, wrap, flush, reset.
module tb_alu_exec_buffer;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [3:0]  alu_ctrl_i;
    logic [31:0] src1_i, src2_i, result_o;
    logic [4:0]  tag_i, tag_o;
    logic        zero_o, ovf_o, illegal_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_buffer #(.DATA_W(32), .TAG_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .alu_ctrl_i(alu_ctrl_i),
        .src1_i(src1_i), .src2_i(src2_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .zero_o(zero_o), .ovf_o(ovf_o), .illegal_o(illegal_o), .tag_o(tag_o)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t);
        in_valid_i = 1'b1;
        alu_ctrl_i = op;
        src1_i     = a;
        src2_i     = b;
        tag_i      = t;
    endtask

    task automatic check_head(input string name, input logic [31:0] res, input logic z,
                              input logic o, input logic ill, input logic [4:0] t);
        check({name, ".valid"},   out_valid_o, 1'b1);
        check({name, ".result"},  result_o,    res);
        check({name, ".zero"},    zero_o,      z);
        check({name, ".ovf"},     ovf_o,       o);
        check({name, ".illegal"}, illegal_o,   ill);
        check({name, ".tag"},     tag_o,       t);
    endtask

    task automatic check_empty(input string name);
        check({name, ".valid"},  out_valid_o, 1'b0);
        check({name, ".result"}, result_o,    32'h0);
        check({name, ".flags"},  {zero_o, ovf_o, illegal_o}, 3'b000);
        check({name, ".tag"},    tag_o,       5'd0);
    endtask

    // Single op through an empty buffer with out_ready_i high: visible after one edge, gone after the next.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [31:0] res,
                          input logic z, input logic o, input logic ill);
        present(op, a, b, t);
        tick();
        in_valid_i = 1'b0;
        check_head(name, res, z, o, ill, t);
        tick();
        check_empty({name, ".drained"});
    endtask

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        alu_ctrl_i = 4'h0; src1_i = '0; src2_i = '0; tag_i = '0;

        tick(); tick();
        check("reset.in_ready", in_ready_o, 1'b0);
        check_empty("reset");
        rst_i = 1'b1;
        #1 check("post_reset.in_ready", in_ready_o, 1'b1);

        out_ready_i = 1'b1;
        run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1,          5'd3, 32'h8000_0000, 0, 1, 0);
        run_op("sub_zero", 4'b0110, 32'd5,         32'd5,          5'd1, 32'h0,         1, 0, 0);
        run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'h1,          5'd2, 32'h7FFF_FFFF, 0, 1, 0);
        run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h1,          5'd4, 32'h1,         0, 0, 0);
        run_op("slt_min",  4'b0111, 32'h8000_0000, 32'h1,          5'd5, 32'h1,         0, 0, 0);
        run_op("slt_no",   4'b0111, 32'h1,         32'hFFFF_FFFF,  5'd6, 32'h0,         1, 0, 0);
        run_op("nor",      4'b1010, 32'h0,         32'h0,          5'd7, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00,  5'd8, 32'h00F0_1200, 0, 0, 0);
        run_op("or",       4'b0001, 32'hF000_0001, 32'h0000_0F00,  5'd9, 32'hF000_0F01, 0, 0, 0);
        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1,          5'd10, 32'h0,        1, 0, 0);
        run_op("illegal",  4'b1111, 32'h1234_5678, 32'h9,          5'd11, 32'h0,        1, 0, 1);

        // Backpressure: two fill the buffer, third waits until the cycle after the first pop.
        out_ready_i = 1'b0;
        present(4'b0010, 32'd1, 32'd2, 5'd1);
        tick();
        present(4'b0010, 32'd10, 32'd20, 5'd2);
        tick();
        present(4'b0110, 32'd100, 32'd1, 5'd4);
        #1 check("full.in_ready", in_ready_o, 1'b0);
        check_head("full.head", 32'd3, 0, 0, 0, 5'd1);
        tick();
        check("full_hold.in_ready", in_ready_o, 1'b0);
        check("full_hold.result", result_o, 32'd3);
        out_ready_i = 1'b1;
        #1 check("full_pop.in_ready", in_ready_o, 1'b0);
        tick();
        check_head("bp.second", 32'd30, 0, 0, 0, 5'd2);
        check("bp.in_ready_after_pop", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        check_head("bp.third", 32'd99, 0, 0, 0, 5'd4);
        tick();
        check_empty("bp.drained");

        // Steady state at count 1: push and pop every cycle across several pointer wraps.
        out_ready_i = 1'b0;
        present(4'b0010, 32'd0, 32'd7, 5'd0);
        tick();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            present(4'b0010, 32'(i * 3), 32'd7, 5'(i));
            #1;
            check("stream.in_ready", in_ready_o, 1'b1);
            check("stream.result", result_o, 32'((i - 1) * 3 + 7));
            check("stream.tag", tag_o, 5'(i - 1));
            tick();
        end
        in_valid_i = 1'b0;
        check_head("stream.last", 32'd37, 0, 0, 0, 5'd10);
        tick();
        check_empty("stream.drained");

        // Flush with a full buffer and a concurrent request.
        out_ready_i = 1'b0;
        present(4'b0010, 32'd1, 32'd1, 5'd12);
        tick();
        present(4'b0010, 32'd2, 32'd2, 5'd13);
        tick();
        present(4'b0010, 32'd3, 32'd3, 5'd14);
        flush_i = 1'b1;
        #1 check("flush.in_ready", in_ready_o, 1'b0);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check_empty("flush");
        present(4'b0010, 32'd9, 32'd9, 5'd15);
        tick();
        in_valid_i = 1'b0;
        check_head("post_flush", 32'd18, 0, 0, 0, 5'd15);
        out_ready_i = 1'b1;
        tick();
        check_empty("post_flush.drained");

        // Reset mid-stream with two entries queued.
        out_ready_i = 1'b0;
        present(4'b0110, 32'd50, 32'd8, 5'd16);
        tick();
        present(4'b0110, 32'd60, 32'd8, 5'd17);
        tick();
        check_head("pre_rst.head", 32'd42, 0, 0, 0, 5'd16);
        rst_i = 1'b0;
        #1 check("rst_low.in_ready", in_ready_o, 1'b0);
        tick();
        check_empty("mid_rst");
        rst_i = 1'b1;
        present(4'b0000, 32'hFF, 32'h0F, 5'd18);
        tick();
        in_valid_i = 1'b0;
        check_head("post_rst", 32'h0F, 0, 0, 0, 5'd18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
